// File: rtl/proc_ctrl_pkg.sv
// rtl/proc_ctrl_pkg.sv - shared run-controller state encoding and sizing helper
package proc_ctrl_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ENC_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ENC_HOLD    = 3'd1;
    localparam logic [STATE_W-1:0] ENC_RELEASE = 3'd2;
    localparam logic [STATE_W-1:0] ENC_RUN     = 3'd3;
    localparam logic [STATE_W-1:0] ENC_DONE    = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = ENC_IDLE,
        ST_HOLD    = ENC_HOLD,
        ST_RELEASE = ENC_RELEASE,
        ST_RUN     = ENC_RUN,
        ST_DONE    = ENC_DONE
    } run_state_e;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_bits(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/core_release_timer.sv
// rtl/core_release_timer.sv - hold/stagger down-counter producing per-core release strobes
module core_release_timer
    import proc_ctrl_pkg::*;
#(
    parameter int NUM_CORES       = 2,
    parameter int RST_HOLD_CYCLES = 4,
    parameter int STAGGER_CYCLES  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 en,
    output logic                 fire,
    output logic                 last,
    output logic [NUM_CORES-1:0] rel_mask
);

    localparam int CNT_MAX = (RST_HOLD_CYCLES > STAGGER_CYCLES) ? RST_HOLD_CYCLES : STAGGER_CYCLES;
    localparam int CNT_W   = cnt_bits(CNT_MAX);
    localparam int IDX_W   = cnt_bits(NUM_CORES - 1);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LOAD = CNT_W'((STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CORES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // A zero count means the edge now being sampled releases core idx_q.
    assign fire = en && (cnt_q == '0);
    assign last = fire && ((STAGGER_CYCLES == 0) || (idx_q == LAST_IDX));

    always_comb begin
        rel_mask = '0;
        if (fire) begin
            if (STAGGER_CYCLES == 0) begin
                rel_mask = '1;
            end else begin
                for (int i = 0; i < NUM_CORES; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        rel_mask[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (load) begin
            cnt_d = HOLD_LOAD;
            idx_d = '0;
        end else if (fire) begin
            cnt_d = STAG_LOAD;
            idx_d = idx_q + IDX_W'(1);
        end else if (en) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/core_run_ctrl.sv
// rtl/core_run_ctrl.sv - sequences core resets, monitors halts and timeout for one run
module core_run_ctrl
    import proc_ctrl_pkg::*;
#(
    parameter int NUM_CORES       = 2,
    parameter int RST_HOLD_CYCLES = 4,
    parameter int STAGGER_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES  = 25,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NUM_CORES-1:0] halt_req,
    output logic [NUM_CORES-1:0] core_resetn,
    output logic                 run_active,
    output logic                 done,
    output logic                 timed_out,
    output logic [NUM_CORES-1:0] halted_mask,
    output logic [CNT_WIDTH-1:0] cycle_count
);

    run_state_e           state_q, state_d;
    logic [NUM_CORES-1:0] core_resetn_q, core_resetn_d;
    logic [NUM_CORES-1:0] halted_mask_q, halted_mask_d;
    logic [CNT_WIDTH-1:0] cycle_count_q, cycle_count_d;
    logic                 timed_out_q, timed_out_d;
    logic                 run_active_q, run_active_d;
    logic                 done_q, done_d;

    logic                 tmr_load;
    logic                 tmr_en;
    logic                 tmr_fire;
    logic                 tmr_last;
    logic [NUM_CORES-1:0] tmr_rel_mask;
    logic [NUM_CORES-1:0] halt_seen;
    logic [CNT_WIDTH-1:0] count_inc;
    logic                 timeout_hit;

    assign tmr_en = (state_q == ST_HOLD) || (state_q == ST_RELEASE);

    core_release_timer #(
        .NUM_CORES      (NUM_CORES),
        .RST_HOLD_CYCLES(RST_HOLD_CYCLES),
        .STAGGER_CYCLES (STAGGER_CYCLES)
    ) u_release_timer (
        .clk     (clk),
        .rst_n   (resetn),
        .load    (tmr_load),
        .en      (tmr_en),
        .fire    (tmr_fire),
        .last    (tmr_last),
        .rel_mask(tmr_rel_mask)
    );

    // Halts only count from cores already out of reset.
    assign halt_seen   = halted_mask_q | (halt_req & core_resetn_q);
    assign count_inc   = (&cycle_count_q) ? cycle_count_q : cycle_count_q + CNT_WIDTH'(1);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (count_inc == CNT_WIDTH'(TIMEOUT_CYCLES));

    always_comb begin
        state_d       = state_q;
        core_resetn_d = core_resetn_q;
        halted_mask_d = halted_mask_q;
        cycle_count_d = cycle_count_q;
        timed_out_d   = timed_out_q;
        tmr_load      = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                core_resetn_d = '0;
                if (start) begin
                    state_d       = ST_HOLD;
                    halted_mask_d = '0;
                    cycle_count_d = '0;
                    timed_out_d   = 1'b0;
                    tmr_load      = 1'b1;
                end
            end
            ST_HOLD, ST_RELEASE: begin
                core_resetn_d = core_resetn_q | tmr_rel_mask;
                halted_mask_d = halt_seen;
                if (tmr_last) begin
                    state_d       = ST_RUN;
                    cycle_count_d = '0;
                end else if (tmr_fire) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RUN: begin
                cycle_count_d = count_inc;
                halted_mask_d = halt_seen;
                // All-halted wins over a coincident timeout.
                if (&halt_seen) begin
                    state_d       = ST_DONE;
                    core_resetn_d = '0;
                    timed_out_d   = 1'b0;
                end else if (timeout_hit) begin
                    state_d       = ST_DONE;
                    core_resetn_d = '0;
                    timed_out_d   = 1'b1;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                core_resetn_d = '0;
            end
        endcase

        if (abort) begin
            state_d       = ST_IDLE;
            core_resetn_d = '0;
            halted_mask_d = '0;
            cycle_count_d = '0;
            timed_out_d   = 1'b0;
            tmr_load      = 1'b0;
        end

        run_active_d = (state_d == ST_RUN);
        done_d       = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            core_resetn_q <= '0;
            halted_mask_q <= '0;
            cycle_count_q <= '0;
            timed_out_q   <= 1'b0;
            run_active_q  <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            core_resetn_q <= core_resetn_d;
            halted_mask_q <= halted_mask_d;
            cycle_count_q <= cycle_count_d;
            timed_out_q   <= timed_out_d;
            run_active_q  <= run_active_d;
            done_q        <= done_d;
        end
    end

    assign core_resetn = core_resetn_q;
    assign run_active  = run_active_q;
    assign done        = done_q;
    assign timed_out   = timed_out_q;
    assign halted_mask = halted_mask_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb/tb_core_run_ctrl.sv - directed and table-driven checks for core_run_ctrl
module tb_core_run_ctrl;

    localparam int NC = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [NC-1:0] halt_req = '0;
    logic [NC-1:0] core_resetn;
    logic [NC-1:0] halted_mask;
    logic          run_active;
    logic          done;
    logic          timed_out;
    logic [31:0]   cycle_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    core_run_ctrl #(
        .NUM_CORES      (2),
        .RST_HOLD_CYCLES(4),
        .STAGGER_CYCLES (2),
        .TIMEOUT_CYCLES (25),
        .CNT_WIDTH      (32)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .abort      (abort),
        .halt_req   (halt_req),
        .core_resetn(core_resetn),
        .run_active (run_active),
        .done       (done),
        .timed_out  (timed_out),
        .halted_mask(halted_mask),
        .cycle_count(cycle_count)
    );

    typedef struct {
        int         h0;
        int         h1;
        int         ab;
        int         end_e;
        logic       exp_done;
        logic       exp_to;
        logic [1:0] exp_mask;
        int         exp_cnt;
    } scen_t;

    scen_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic start_run();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_core_resetn"}, 32'(core_resetn), 32'd0);
        chk({tag, "_run_active"}, 32'(run_active), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_timed_out"}, 32'(timed_out), 32'd0);
        chk({tag, "_halted_mask"}, 32'(halted_mask), 32'd0);
        chk({tag, "_cycle_count"}, cycle_count, 32'd0);
    endtask

    initial begin
        // {h0, h1, abort_edge, end_edge, done, timed_out, mask, count}
        tbl[0] = '{0,  0,  0,  31, 1'b1, 1'b1, 2'b00, 25};
        tbl[1] = '{9,  13, 0,  13, 1'b1, 1'b0, 2'b11, 7};
        tbl[2] = '{1,  1,  0,  7,  1'b1, 1'b0, 2'b11, 1};
        tbl[3] = '{1,  31, 0,  31, 1'b1, 1'b0, 2'b11, 25};
        tbl[4] = '{0,  8,  0,  31, 1'b1, 1'b1, 2'b10, 25};
        tbl[5] = '{0,  0,  10, 10, 1'b0, 1'b0, 2'b00, 0};
        tbl[6] = '{20, 20, 0,  20, 1'b1, 1'b0, 2'b11, 14};
        tbl[7] = '{0,  0,  2,  2,  1'b0, 1'b0, 2'b00, 0};

        step();
        chk_idle("in_reset");
        step();
        resetn = 1'b1;
        step();
        step();
        step();
        chk_idle("idle_after_reset");

        // Release timing, start ignored in RUN
        start_run();
        chk("e0_core_resetn", 32'(core_resetn), 32'd0);
        step(); step(); step();
        chk("e3_core_resetn", 32'(core_resetn), 32'd0);
        step();
        chk("e4_core_resetn", 32'(core_resetn), 32'd1);
        step();
        chk("e5_core_resetn", 32'(core_resetn), 32'd1);
        chk("e5_run_active", 32'(run_active), 32'd0);
        step();
        chk("e6_core_resetn", 32'(core_resetn), 32'd3);
        chk("e6_run_active", 32'(run_active), 32'd1);
        chk("e6_cycle_count", cycle_count, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("e7_cycle_count", cycle_count, 32'd1);
        chk("e7_core_resetn", 32'(core_resetn), 32'd3);
        step(); step(); step();
        chk("e10_cycle_count", cycle_count, 32'd4);

        // Asynchronous reset between edges
        #2 resetn = 1'b0;
        #1 chk_idle("async_reset");
        step();
        resetn = 1'b1;
        step();
        step();
        chk_idle("post_async_idle");

        // Restart, early halts ignored until release, DONE frozen, start+abort
        start_run();
        halt_req = 2'b11;
        step(); step(); step(); step();
        chk("rs_e4_core_resetn", 32'(core_resetn), 32'd1);
        step(); step();
        chk("rs_e6_core_resetn", 32'(core_resetn), 32'd3);
        chk("rs_e6_run_active", 32'(run_active), 32'd1);
        step();
        chk("rs_e7_done", 32'(done), 32'd1);
        chk("rs_e7_cycle_count", cycle_count, 32'd1);
        chk("rs_e7_timed_out", 32'(timed_out), 32'd0);
        chk("rs_e7_core_resetn", 32'(core_resetn), 32'd0);
        halt_req = 2'b00;
        step(); step(); step();
        chk("frozen_done", 32'(done), 32'd1);
        chk("frozen_cycle_count", cycle_count, 32'd1);
        chk("frozen_halted_mask", 32'(halted_mask), 32'd3);
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk_idle("start_abort_in_done");

        for (int s = 0; s < 8; s++) begin
            int first;
            first = -1;
            start_run();
            for (int k = 1; k <= 40; k++) begin
                halt_req[0] = (tbl[s].h0 != 0) && (k >= tbl[s].h0);
                halt_req[1] = (tbl[s].h1 != 0) && (k >= tbl[s].h1);
                abort = (k == tbl[s].ab);
                step();
                abort = 1'b0;
                if (done && first < 0) first = k;
                if (k == tbl[s].end_e) begin
                    chk($sformatf("s%0d_done", s), 32'(done), 32'(tbl[s].exp_done));
                    chk($sformatf("s%0d_timed_out", s), 32'(timed_out), 32'(tbl[s].exp_to));
                    chk($sformatf("s%0d_halted_mask", s), 32'(halted_mask), 32'(tbl[s].exp_mask));
                    chk($sformatf("s%0d_cycle_count", s), cycle_count, 32'(tbl[s].exp_cnt));
                    chk($sformatf("s%0d_core_resetn", s), 32'(core_resetn), 32'd0);
                    chk($sformatf("s%0d_run_active", s), 32'(run_active), 32'd0);
                    break;
                end
            end
            halt_req = '0;
            if (tbl[s].exp_done) begin
                chk($sformatf("s%0d_first_done_edge", s), 32'(first), 32'(tbl[s].end_e));
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_run_ctrl.md
CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

Interface
REQ-001 SHALL have parameter NUM_CORES, default 2: number of processor cores sequenced (1..16).
REQ-002 SHALL have parameter RST_HOLD_CYCLES, default 4: cycles all cores are held in reset after start (>=1).
REQ-003 SHALL have parameter STAGGER_CYCLES, default 2: cycles between successive core reset releases (>=0).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 25: run-cycle limit; 0 disables the timeout.
REQ-005 SHALL have parameter CNT_WIDTH, default 32: width of cycle_count.
REQ-006 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-007 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port start, input, 1: launch a run; sampled in IDLE and DONE only.
REQ-009 SHALL have port abort, input, 1: force return to IDLE from any state.
REQ-010 SHALL have port halt_req, input, NUM_CORES: per-core halt indication (e.g. ebreak retired).
REQ-011 SHALL have port core_resetn, output, NUM_CORES: registered active-low reset to each core.
REQ-012 SHALL have port run_active, output, 1: high while in RUN.
REQ-013 SHALL have port done, output, 1: high while in DONE.
REQ-014 SHALL have port timed_out, output, 1: valid in DONE; 1 = run ended by timeout.
REQ-015 SHALL have port halted_mask, output, NUM_CORES: sticky per-core halt flags for current run.
REQ-016 SHALL have port cycle_count, output, CNT_WIDTH: RUN cycles elapsed, frozen in DONE.

Function
REQ-017 SHALL implement FSM states IDLE, HOLD, RELEASE, RUN, DONE; all outputs registered.
REQ-018 IDLE: core_resetn all 0; start=1 -> HOLD at next edge; cycle_count, halted_mask, timed_out cleared on that edge.
REQ-019 HOLD: core_resetn all 0 for exactly RST_HOLD_CYCLES cycles; with start sampled at edge E0, HOLD exits at edge E0+RST_HOLD_CYCLES.
REQ-020 RELEASE/stagger: core_resetn[i] SHALL go 1 at edge E0+RST_HOLD_CYCLES+i*STAGGER_CYCLES; once released, stays 1 until RUN/RELEASE exit.
REQ-021 RUN SHALL be entered on the edge releasing core NUM_CORES-1 (RELEASE skipped when NUM_CORES=1 or STAGGER_CYCLES=0), with cycle_count=0.
REQ-022 RUN: cycle_count SHALL increment on every edge, saturating at all-ones.
REQ-023 RUN: halted_mask[i] SHALL set when halt_req[i]=1 is sampled and core_resetn[i]=1; halt_req from a core still in reset (HOLD/RELEASE) SHALL be ignored.
REQ-024 RUN -> DONE with timed_out=0 on the edge where halted_mask including currently sampled halt_req becomes all ones.
REQ-025 RUN -> DONE with timed_out=1 on the edge where incremented cycle_count equals TIMEOUT_CYCLES (TIMEOUT_CYCLES!=0).
REQ-026 Simultaneous all-halted and timeout SHALL give timed_out=0.
REQ-027 DONE: core_resetn all 0 on entry edge; done=1; cycle_count, halted_mask, timed_out frozen; start=1 -> HOLD per REQ-018.
REQ-028 start in HOLD, RELEASE or RUN SHALL be ignored.
REQ-029 abort=1 in any state SHALL go to IDLE next edge: core_resetn all 0, cycle_count/halted_mask/timed_out cleared; abort has priority over start and over DONE transitions.

Reset
REQ-030 resetn=0 SHALL immediately force IDLE, core_resetn=0, run_active=0, done=0, timed_out=0, halted_mask=0, cycle_count=0, including mid-run.
REQ-031 After resetn rises, block SHALL stay in IDLE until start.

Structure
REQ-032 FSM state enum and state-encoding constants SHALL live in shared package proc_ctrl_pkg.
REQ-033 Per-core release timing SHALL use one sub-module, core_release_timer, holding the HOLD/stagger down-counter and release index.

Verification (defaults; E0 = edge sampling start)
REQ-034 start pulse -> core_resetn=01 at E0+4, =11 and run_active=1 at E0+6, cycle_count=0.
REQ-035 no halt_req -> at E0+31 done=1, timed_out=1, cycle_count=25, core_resetn=00.
REQ-036 halt_req[0] at E0+9, halt_req[1] at E0+13 -> done=1 at E0+13, timed_out=0, halted_mask=11, cycle_count=7.
REQ-037 halt_req=11 held from E0+1 -> ignored until released; done at E0+7 with cycle_count=1, timed_out=0; last halt at E0+31 with count 25 -> timed_out=0.
REQ-038 abort at E0+10 -> IDLE at E0+10, core_resetn=00, cycle_count=0; start+abort together in DONE -> IDLE.
REQ-039 resetn low mid-RUN (asynchronous, between edges) -> all outputs reset immediately; start after release -> normal sequence per REQ-034.
